// File: rtl/bklight_pixel_compensation.sv
// bklight_pixel_compensation
// Boosts linear RGB pixels by gain = 1023/frame_max so the perceived image is
// unchanged while the backlight is dimmed. The gain is computed once per frame
// by an 18-step restoring divider and committed only outside active video.
// The pixel path is a fixed 3-stage pipeline: register, multiply, round/saturate.
// Optional feature macro: BKLIGHT_GAIN_SMOOTH_EN (temporal IIR on gain commits).
module bklight_pixel_compensation #(
    parameter int DATA_WIDTH = 10,
    parameter int GAIN_FRAC  = 8,
    parameter int MIN_MAX    = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            frame_start,
    input  logic [DATA_WIDTH-1:0]           frame_max,
    input  logic                            in_de,
    input  logic                            in_vsync,
    input  logic                            in_hsync,
    input  logic [DATA_WIDTH-1:0]           in_r,
    input  logic [DATA_WIDTH-1:0]           in_g,
    input  logic [DATA_WIDTH-1:0]           in_b,
    output logic                            out_de,
    output logic                            out_vsync,
    output logic                            out_hsync,
    output logic [DATA_WIDTH-1:0]           out_r,
    output logic [DATA_WIDTH-1:0]           out_g,
    output logic [DATA_WIDTH-1:0]           out_b,
    output logic [DATA_WIDTH+GAIN_FRAC-1:0] gain,
    output logic                            gain_busy,
    output logic                            gain_valid
);

    localparam int GW = DATA_WIDTH + GAIN_FRAC;   // gain width
    localparam int PW = DATA_WIDTH + GW;          // product width
    localparam int QW = PW - GAIN_FRAC + 1;       // rounded, unscaled width
    localparam int CW = $clog2(GW);               // division step counter width

    localparam logic [GW-1:0]         DIVIDEND  = GW'((1 << DATA_WIDTH) - 1) << GAIN_FRAC;
    localparam logic [GW-1:0]         UNITY     = GW'(1) << GAIN_FRAC;
    localparam logic [DATA_WIDTH-1:0] MIN_M     = DATA_WIDTH'(MIN_MAX);
    localparam logic [CW-1:0]         LAST_STEP = CW'(GW - 1);
    localparam logic [PW:0]           ROUND     = (PW + 1)'(1) << (GAIN_FRAC - 1);
    localparam logic [QW-1:0]         PIX_MAX   = QW'({DATA_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        COMMIT
    } state_t;

    // Control / divider state
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   m_q, m_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [GW-1:0]           quot_q, quot_d;
    logic [GW-1:0]           gain_q, gain_d;
    logic                    gain_valid_q, gain_valid_d;
    logic [DATA_WIDTH:0]     trial;
    logic [DATA_WIDTH:0]     diff;
    logic [GW-1:0]           commit_gain;

    // Pixel pipeline: index 0 = R, 1 = G, 2 = B; sync bits are {de, vsync, hsync}
    logic [2:0][DATA_WIDTH-1:0] s1_pix_q, s1_pix_d;
    logic [2:0]                 s1_sync_q, s1_sync_d;
    logic [2:0][PW-1:0]         s2_prod_q, s2_prod_d;
    logic [2:0]                 s2_sync_q, s2_sync_d;
    logic [2:0][DATA_WIDTH-1:0] out_pix_q, out_pix_d;
    logic [2:0]                 out_sync_q, out_sync_d;

    // Round half up, drop the fractional bits, clamp to full scale
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [PW-1:0] prod);
        logic [PW:0]   rounded;
        logic [QW-1:0] q;
        rounded = {1'b0, prod} + ROUND;
        q       = rounded[PW:GAIN_FRAC];
        if (q > PIX_MAX) begin
            return {DATA_WIDTH{1'b1}};
        end
        return q[DATA_WIDTH-1:0];
    endfunction

`ifdef BKLIGHT_GAIN_SMOOTH_EN
    logic [GW+1:0] smooth_sum;

    // Temporal IIR: new gain = (3*old + quotient + 2) / 4
    always_comb begin
        smooth_sum  = {1'b0, gain_q, 1'b0} + {2'b00, gain_q} + {2'b00, quot_q} + (GW + 2)'(2);
        commit_gain = smooth_sum[GW+1:2];
    end
`else
    assign commit_gain = quot_q;
`endif

    // Gain FSM: latch divisor, restoring division MSB first, commit during blanking
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        m_d          = m_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        gain_d       = gain_q;
        gain_valid_d = 1'b0;
        trial        = {rem_q, DIVIDEND[cnt_q]};
        diff         = trial - {1'b0, m_q};

        if (frame_start) begin
            // A new frame always (re)starts the division; any run in flight is dropped.
            state_d = DIV;
            cnt_d   = LAST_STEP;
            m_d     = (frame_max < MIN_M) ? MIN_M : frame_max;
            rem_d   = '0;
            quot_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                DIV: begin
                    if (trial >= {1'b0, m_q}) begin
                        rem_d  = diff[DATA_WIDTH-1:0];
                        quot_d = {quot_q[GW-2:0], 1'b1};
                    end else begin
                        rem_d  = trial[DATA_WIDTH-1:0];
                        quot_d = {quot_q[GW-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                COMMIT: begin
                    // Hold the new gain back until active video ends: no mid-line step.
                    if (!in_de) begin
                        gain_d       = commit_gain;
                        gain_valid_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control and divider registers; gain resets to unity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            m_q          <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            gain_q       <= UNITY;
            gain_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            m_q          <= m_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            gain_q       <= gain_d;
            gain_valid_q <= gain_valid_d;
        end
    end

    // Pixel datapath: S1 capture, S2 multiply by the current gain, S3 round/saturate
    always_comb begin
        s1_pix_d[0] = in_r;
        s1_pix_d[1] = in_g;
        s1_pix_d[2] = in_b;
        s1_sync_d   = {in_de, in_vsync, in_hsync};
        s2_sync_d   = s1_sync_q;
        out_sync_d  = s2_sync_q;
        for (int c = 0; c < 3; c++) begin
            s2_prod_d[c] = PW'(s1_pix_q[c]) * PW'(gain_q);
            out_pix_d[c] = round_sat(s2_prod_q[c]);
        end
    end

    // Pipeline registers; never stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the datapath is reset too, so outputs read as zero straight out of reset.
            s1_pix_q   <= '0;
            s1_sync_q  <= '0;
            s2_prod_q  <= '0;
            s2_sync_q  <= '0;
            out_pix_q  <= '0;
            out_sync_q <= '0;
        end else begin
            s1_pix_q   <= s1_pix_d;
            s1_sync_q  <= s1_sync_d;
            s2_prod_q  <= s2_prod_d;
            s2_sync_q  <= s2_sync_d;
            out_pix_q  <= out_pix_d;
            out_sync_q <= out_sync_d;
        end
    end

    assign out_r      = out_pix_q[0];
    assign out_g      = out_pix_q[1];
    assign out_b      = out_pix_q[2];
    assign out_de     = out_sync_q[2];
    assign out_vsync  = out_sync_q[1];
    assign out_hsync  = out_sync_q[0];
    assign gain       = gain_q;
    assign gain_valid = gain_valid_q;
    assign gain_busy  = (state_q != IDLE);

endmodule
